zigzag_serializer: RTL and testbench
====================================

Name: zigzag_serializer

Overview:
- Sits directly downstream of the per-channel quantizers (Y/Cb/Cr).
- Captures one quantized 8x8 block in parallel when the quantizer's out_enable pulses.
- Emits the 64 coefficients serially in JPEG zigzag order over a valid/ready stream to the run-length/Huffman entropy stage.
- Double-buffered (ping-pong), so a new block can be accepted while the previous one is still streaming.

Parameters:
- COEF_W, 11, width of each input coefficient (signed).
- OUT_W, 12, width of out_coeff (signed); must be ≥ COEF_W+1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_enable  input  1  one-cycle strobe: in_block is valid this cycle (driven by quantizer out_enable).
- in_block  input  [0:7][0:7] x COEF_W signed  quantized block, row-major [row][col].
- in_ready  output  1  at least one bank free; a strobe is accepted only when high.
- overflow  output  1  sticky flag: in_enable arrived while in_ready was low.
- out_valid  output  1  out_coeff/out_index/out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_coeff  output  OUT_W signed  current coefficient, sign-extended.
- out_index  output  6  zigzag position 0..63.
- out_last  output  1  high with index 63.

Behaviour:
- Reset: banks invalid, wr_ptr=0, rd_ptr=0, full_cnt=0, rd_idx=0, overflow=0, out_valid=0, out_coeff=0, out_index=0, out_last=0. Reset mid-stream discards all buffered data; no partial beats after reset.
- in_ready = (full_cnt < 2), decoded from registered state. No combinational path from in_enable or out_ready.
- Write:
  - in_enable && in_ready: store in_block into bank[wr_ptr], toggle wr_ptr, full_cnt+1.
  - in_enable && !in_ready: block dropped, overflow<=1 (cleared only by rst).
- Read FSM states:
  - IDLE: out_valid=0. If full_cnt>0, go to STREAM with rd_idx=0.
  - STREAM: out_valid=1; out_coeff = bank[rd_ptr][ZZ_ROW[rd_idx]][ZZ_COL[rd_idx]].
    - Handshake (out_valid && out_ready) advances rd_idx.
    - On the handshake at rd_idx=63: toggle rd_ptr, full_cnt-1, rd_idx=0. Stay in STREAM if another bank is full (no bubble), else go to IDLE.
- Output registers hold stable while out_valid && !out_ready.
- Latency: block accepted at cycle N gives out_valid with index 0 at cycle N+1, provided the FSM is idle.
- Throughput: 64 cycles/block with out_ready held high; back-to-back blocks are gapless.
- Simultaneous write and final-beat release in the same cycle: full_cnt unchanged.
  - Write is evaluated against the pre-release full_cnt, so at full_cnt=2 the write is dropped even though a bank frees that cycle.
- Zigzag order (row,col), fixed: (0,0),(0,1),(1,0),(2,0),(1,1),(0,2),(0,3),(1,2),(2,1),(3,0),… through (7,7).

Optional Feature:
- Macro DC_DPCM_EN.
- Defined:
  - Register prev_dc (COEF_W+1 bits, reset 0).
  - On the index-0 beat, out_coeff = dc − prev_dc (OUT_W signed, no saturation; range fits since OUT_W ≥ COEF_W+1).
  - prev_dc <= dc on the index-0 handshake only.
  - AC beats unaffected.
- Undefined: DC passes through sign-extended like AC; no prev_dc register.

Decomposition:
- Package jpeg_zz_pkg:
  - coef_t (COEF_W signed), block_t (8x8 coef_t).
  - ZZ_ROW[0:63] and ZZ_COL[0:63] localparam tables.
  - ZZ_LAST=63.
- Sub-module zz_bank_buffer:
  - Two-bank storage with wr_ptr/rd_ptr/full_cnt and in_ready/overflow.
  - Top level holds the read FSM, the zigzag mux and the DPCM logic.

Test Plan:
- Ramp block in_block[r][c]=8r+c, out_ready=1 → 64 beats: 0,1,8,16,9,2,3,10,17,24,… ending 63; out_last only on beat 63; first out_valid 1 cycle after strobe.
- Negative values: all entries −1024 → 64 beats of 12'hC00, sign-extended correctly.
- Backpressure: out_ready toggles 1,0,0,1,… → no beat lost or duplicated; outputs stable while stalled; order identical to the ramp case.
- Three strobes spaced 1 cycle apart with out_ready=0 → first two accepted (in_ready low after the second), third dropped, overflow=1; releasing out_ready streams exactly 128 beats, gapless across the bank boundary.
- rst asserted at beat 30 of a block → next cycle out_valid=0, in_ready=1, overflow=0; a fresh block streams from index 0.
- DC_DPCM_EN defined: blocks with DC 50, 30, −20 → index-0 outputs 50, −20, −50; AC beats unchanged. Without the macro: 50, 30, −20.

Source files
------------

// File: rtl/jpeg_zz_pkg.sv
// Shared types and the JPEG zigzag scan tables for the zigzag serializer.
package jpeg_zz_pkg;

  localparam int ZZ_COEF_W = 11;
  localparam int ZZ_OUT_W  = 12;

  typedef logic signed [ZZ_COEF_W-1:0] coef_t;
  typedef coef_t [0:7][0:7] block_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  localparam logic [5:0] ZZ_LAST = 6'd63;

  // Row/column of the coefficient emitted at each zigzag position.
  localparam int ZZ_ROW [0:63] = '{
    0,0,1,2,1,0,0,1,2,3, 4,3,2,1,0,0,1,2,3,4, 5,6,5,4,3,2,1,0,0,1,
    2,3,4,5,6,7,7,6,5,4, 3,2,1,2,3,4,5,6,7,7, 6,5,4,3,4,5,6,7,7,6,
    5,6,7,7
  };
  localparam int ZZ_COL [0:63] = '{
    0,1,0,0,1,2,3,2,1,0, 0,1,2,3,4,5,4,3,2,1, 0,0,1,2,3,4,5,6,7,6,
    5,4,3,2,1,0,1,2,3,4, 5,6,7,7,6,5,4,3,2,3, 4,5,6,7,7,6,5,4,5,6,
    7,7,6,7
  };

  function automatic logic [2:0] zz_row(input logic [5:0] idx);
    return 3'(ZZ_ROW[idx]);
  endfunction

  function automatic logic [2:0] zz_col(input logic [5:0] idx);
    return 3'(ZZ_COL[idx]);
  endfunction

endpackage

// File: rtl/zz_bank_buffer.sv
// Ping-pong storage for two 8x8 blocks: write/read pointers, occupancy,
// in_ready and the sticky overflow flag.
module zz_bank_buffer
  import jpeg_zz_pkg::*;
#(
  parameter int COEF_W = ZZ_COEF_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [0:7][0:7][COEF_W-1:0]  wr_block,
  input  logic                         rd_release,
  output logic                         wr_accept,
  output logic                         in_ready,
  output logic                         overflow,
  output logic [1:0]                   full_cnt,
  output logic [0:7][0:7][COEF_W-1:0]  rd_block
);

  logic [0:7][0:7][COEF_W-1:0] bank_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] full_cnt_q;
  logic       overflow_q;

  // Acceptance uses the pre-release count: a bank freed this cycle is not
  // reusable until the next one.
  assign in_ready  = (full_cnt_q != 2'd2);
  assign wr_accept = wr_en && in_ready;
  assign overflow  = overflow_q;
  assign full_cnt  = full_cnt_q;
  assign rd_block  = bank_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      full_cnt_q <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= ~wr_ptr_q;
      if (rd_release) rd_ptr_q <= ~rd_ptr_q;
      case ({wr_accept, rd_release})
        2'b10:   full_cnt_q <= full_cnt_q + 2'd1;
        2'b01:   full_cnt_q <= full_cnt_q - 2'd1;
        default: full_cnt_q <= full_cnt_q;
      endcase
      if (wr_en && !in_ready) overflow_q <= 1'b1;
    end
  end

  // Bank contents need no reset; full_cnt alone marks them valid.
  always_ff @(posedge clk) begin
    if (wr_accept) bank_q[wr_ptr_q] <= wr_block;
  end

endmodule

// File: rtl/zigzag_serializer.sv
// Captures quantized 8x8 blocks and streams them in JPEG zigzag order.
// Optional DC differencing against the previous block: define DC_DPCM_EN.
module zigzag_serializer
  import jpeg_zz_pkg::*;
#(
  parameter int COEF_W = ZZ_COEF_W,
  parameter int OUT_W  = ZZ_OUT_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_enable,
  input  logic signed [0:7][0:7][COEF_W-1:0] in_block,
  output logic                               in_ready,
  output logic                               overflow,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [OUT_W-1:0]            out_coeff,
  output logic [5:0]                         out_index,
  output logic                               out_last,
  output rd_state_t                          dbg_state
);

  // Stream handshake: a beat transfers on a rising clk edge where out_valid
  // and out_ready are both high; while out_valid is high and out_ready low,
  // out_coeff/out_index/out_last stay unchanged and out_valid stays high.

  logic                        wr_accept;
  logic                        rd_release;
  logic [1:0]                  full_cnt;
  logic [0:7][0:7][COEF_W-1:0] rd_block;

  rd_state_t  state_q, state_d;
  logic [5:0] rd_idx_q, rd_idx_d;
  logic       hs;

  zz_bank_buffer #(.COEF_W(COEF_W)) u_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (in_enable),
    .wr_block   (in_block),
    .rd_release (rd_release),
    .wr_accept  (wr_accept),
    .in_ready   (in_ready),
    .overflow   (overflow),
    .full_cnt   (full_cnt),
    .rd_block   (rd_block)
  );

  assign out_valid = (state_q == RD_STREAM);
  assign hs        = out_valid && out_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    rd_release = 1'b0;
    case (state_q)
      RD_IDLE: begin
        // Looking at the incoming write gives index 0 the cycle after capture.
        if (full_cnt != 2'd0 || wr_accept) begin
          state_d  = RD_STREAM;
          rd_idx_d = 6'd0;
        end
      end
      RD_STREAM: begin
        if (hs) begin
          if (rd_idx_q == ZZ_LAST) begin
            rd_release = 1'b1;
            rd_idx_d   = 6'd0;
            if (!(full_cnt == 2'd2 || wr_accept)) state_d = RD_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 6'd1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RD_IDLE;
      rd_idx_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  logic signed [COEF_W-1:0] cur_coef;
  logic signed [OUT_W-1:0]  coef_ext;
  logic signed [OUT_W-1:0]  beat_coef;

  assign cur_coef = rd_block[zz_row(rd_idx_q)][zz_col(rd_idx_q)];
  assign coef_ext = OUT_W'(cur_coef);

`ifdef DC_DPCM_EN
  logic signed [COEF_W:0] prev_dc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_dc_q <= '0;
    end else if (hs && rd_idx_q == 6'd0) begin
      prev_dc_q <= (COEF_W+1)'(cur_coef);
    end
  end

  assign beat_coef = (rd_idx_q == 6'd0) ? (coef_ext - OUT_W'(prev_dc_q)) : coef_ext;
`else
  assign beat_coef = coef_ext;
`endif

  // Outputs decode registered state only, so they hold steady under stall.
  assign out_coeff = out_valid ? beat_coef : '0;
  assign out_index = rd_idx_q;
  assign out_last  = out_valid && (rd_idx_q == ZZ_LAST);

endmodule

// File: tb/tb_zigzag_serializer.sv
// Self-checking bench for zigzag_serializer (honours DC_DPCM_EN when defined).
module tb_zigzag_serializer;
  import jpeg_zz_pkg::*;

  localparam int COEF_W = 11;
  localparam int OUT_W  = 12;
  localparam int BEAT_W = OUT_W + 7;

  logic                               clk = 1'b0;
  logic                               rst = 1'b1;
  logic                               in_enable = 1'b0;
  logic signed [0:7][0:7][COEF_W-1:0] in_block = '0;
  logic                               in_ready;
  logic                               overflow;
  logic                               out_valid;
  logic                               out_ready = 1'b0;
  logic signed [OUT_W-1:0]            out_coeff;
  logic [5:0]                         out_index;
  logic                               out_last;
  rd_state_t                          dbg_state;

  zigzag_serializer #(.COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_enable (in_enable),
    .in_block  (in_block),
    .in_ready  (in_ready),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeff (out_coeff),
    .out_index (out_index),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] got_q[$];
  int checks = 0;
  int failures = 0;
  int zz_r[64];
  int zz_c[64];
  int model_prev = 0;
  logic model_ovf = 1'b0;
  logic stalled_prev = 1'b0;
  logic [BEAT_W-1:0] stall_beat = '0;

  // Zigzag order from the anti-diagonal walk: even diagonals run bottom-left
  // to top-right, odd diagonals top-right to bottom-left.
  function automatic void build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_r[n] = r; zz_c[n] = s - r; n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_r[n] = r; zz_c[n] = s - r; n++; end
      end
    end
  endfunction

  task automatic push_block(input logic [0:7][0:7][COEF_W-1:0] b);
    for (int k = 0; k < 64; k++) begin
      int v;
      logic [OUT_W-1:0] cv;
      v = int'($signed(b[zz_r[k]][zz_c[k]]));
`ifdef DC_DPCM_EN
      if (k == 0) begin
        int dc;
        dc = v;
        v = dc - model_prev;
        model_prev = dc;
      end
`endif
      cv = v[OUT_W-1:0];
      exp_q.push_back({(k == 63), 6'(k), cv});
    end
  endtask

  // One clock: check outputs at the negedge, apply model updates at the posedge.
  task automatic step();
    logic do_pop, do_push;
    int occ;
    logic [BEAT_W-1:0] beat;
    logic [0:7][0:7][COEF_W-1:0] cap;
    @(negedge clk);
    do_pop = 1'b0;
    do_push = 1'b0;
    cap = in_block;
    occ = (exp_q.size() + 63) / 64;
    beat = {out_last, out_index, out_coeff};
    if (!rst) begin
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL out_valid got=%b exp=%b", out_valid, exp_q.size() != 0);
      end
      checks++;
      if (in_ready !== (occ < 2)) begin
        failures++;
        $display("FAIL in_ready got=%b exp=%b", in_ready, occ < 2);
      end
      checks++;
      if (overflow !== model_ovf) begin
        failures++;
        $display("FAIL overflow got=%b exp=%b", overflow, model_ovf);
      end
      if (stalled_prev && out_valid) begin
        checks++;
        if (beat !== stall_beat) begin
          failures++;
          $display("FAIL stall_hold got=%h exp=%h", beat, stall_beat);
        end
      end
      if (out_valid && exp_q.size() != 0) begin
        checks++;
        if (beat !== exp_q[0]) begin
          failures++;
          $display("FAIL beat got=%h exp=%h", beat, exp_q[0]);
        end
        if (out_ready) begin
          do_pop = 1'b1;
          got_q.push_back(beat);
        end
      end
      if (in_enable) begin
        if (occ < 2) do_push = 1'b1;
        else model_ovf = 1'b1;
      end
      stalled_prev = out_valid && !out_ready;
      stall_beat = beat;
    end else begin
      stalled_prev = 1'b0;
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      model_ovf = 1'b0;
      model_prev = 0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) push_block(cap);
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_ramp();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) in_block[r][c] = COEF_W'(8 * r + c);
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) in_block[r][c] = COEF_W'(v);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) in_block[r][c] = COEF_W'($urandom_range(0, 2047));
  endtask

  task automatic strobe();
    in_enable = 1'b1;
    step();
    in_enable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_enable = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout remaining=%0d exp=0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_ready = 1'b1;
    fill_random();
    rst = 1'b1;
    in_enable = 1'b1;
    repeat (3) step();
    in_enable = 1'b0;
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, overflow, out_last} !== 4'b0100 || out_coeff !== '0 ||
        out_index !== 6'd0 || dbg_state !== RD_IDLE) begin
      failures++;
      $display("FAIL reset_state got=v%b r%b o%b l%b c%h i%0d exp=v0 r1 o0 l0 c000 i0",
               out_valid, in_ready, overflow, out_last, out_coeff, out_index);
    end
    repeat (2) step();
  endtask

  task automatic test_ramp();
    int ramp_head[10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
    int lasts = 0;
    do_reset();
    out_ready = 1'b1;
    fill_ramp();
    strobe();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 6'd0) begin
      failures++;
      $display("FAIL ramp_latency got=v%b i%0d exp=v1 i0", out_valid, out_index);
    end
    drain(100);
    checks++;
    if (got_q.size() != 64) begin
      failures++;
      $display("FAIL ramp_count got=%0d exp=64", got_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (got_q[k][OUT_W-1:0] !== OUT_W'(ramp_head[k])) begin
          failures++;
          $display("FAIL ramp_order k=%0d got=%0d exp=%0d", k, got_q[k][OUT_W-1:0], ramp_head[k]);
        end
      end
      for (int k = 0; k < 64; k++) if (got_q[k][BEAT_W-1]) lasts++;
      checks++;
      if (lasts != 1 || got_q[63][BEAT_W-1] !== 1'b1 || got_q[63][OUT_W-1:0] !== 12'd63) begin
        failures++;
        $display("FAIL ramp_last got=lasts%0d tail%h exp=lasts1 tail%h", lasts, got_q[63], {1'b1, 6'd63, 12'd63});
      end
    end
  endtask

  task automatic test_negative();
    do_reset();
    out_ready = 1'b1;
    fill_const(-1024);
    strobe();
    drain(100);
    checks++;
    if (got_q.size() != 64) begin
      failures++;
      $display("FAIL neg_count got=%0d exp=64", got_q.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (got_q[k][OUT_W-1:0] !== 12'hC00) begin
          failures++;
          $display("FAIL neg_value k=%0d got=%h exp=c00", k, got_q[k][OUT_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    fill_ramp();
    strobe();
    while (exp_q.size() != 0 && n < 400) begin
      out_ready = (n % 3 == 0);
      step();
      n++;
    end
    out_ready = 1'b1;
    checks++;
    if (got_q.size() != 64) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=64", got_q.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (got_q[k][OUT_W-1:0] !== OUT_W'(8 * zz_r[k] + zz_c[k]) || got_q[k][OUT_W+5:OUT_W] !== 6'(k)) begin
          failures++;
          $display("FAIL bp_order k=%0d got=%h exp_coeff=%0d", k, got_q[k], 8 * zz_r[k] + zz_c[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int cycles = 0;
    do_reset();
    out_ready = 1'b0;
    fill_ramp();
    strobe();
    step();
    fill_random();
    strobe();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ovf_in_ready got=%b exp=0", in_ready);
    end
    step();
    fill_random();
    strobe();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag got=%b exp=1", overflow);
    end
    out_ready = 1'b1;
    while (exp_q.size() != 0 && cycles < 300) begin step(); cycles++; end
    checks++;
    if (got_q.size() != 128 || cycles != 128) begin
      failures++;
      $display("FAIL ovf_stream got=beats%0d cycles%0d exp=beats128 cycles128", got_q.size(), cycles);
    end
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    fill_random();
    strobe();
    fill_random();
    strobe();
    strobe();
    while (!(out_valid && out_index == 6'd30) && n < 200) begin step(); n++; end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL mid_reach got=timeout exp=index30");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=v%b r%b o%b exp=v0 r1 o0", out_valid, in_ready, overflow);
    end
    fill_ramp();
    strobe();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 6'd0) begin
      failures++;
      $display("FAIL mid_fresh got=v%b i%0d exp=v1 i0", out_valid, out_index);
    end
    drain(100);
    checks++;
    if (got_q.size() != 64) begin
      failures++;
      $display("FAIL mid_count got=%0d exp=64", got_q.size());
    end
  endtask

  task automatic test_dc();
    int dcs[3] = '{50, 30, -20};
`ifdef DC_DPCM_EN
    int dc_exp[3] = '{50, -20, -50};
`else
    int dc_exp[3] = '{50, 30, -20};
`endif
    int j = 0;
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      fill_random();
      in_block[0][0] = COEF_W'(dcs[b]);
      strobe();
      drain(100);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      if (got_q[k][OUT_W+5:OUT_W] == 6'd0 && j < 3) begin
        checks++;
        if (got_q[k][OUT_W-1:0] !== OUT_W'(dc_exp[j])) begin
          failures++;
          $display("FAIL dc_value blk=%0d got=%0d exp=%0d", j, $signed(got_q[k][OUT_W-1:0]), dc_exp[j]);
        end
        j++;
      end
    end
    checks++;
    if (j != 3) begin
      failures++;
      $display("FAIL dc_count got=%0d exp=3", j);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        fill_random();
        in_enable = 1'b1;
      end else begin
        in_enable = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_enable = 1'b0;
    out_ready = 1'b1;
    drain(300);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    build_zz();
    test_reset();
    test_ramp();
    test_negative();
    test_backpressure();
    test_overflow();
    test_reset_midstream();
    test_dc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
